// File: rtl/vga_hvsync_generator.sv
// vga_hvsync_generator
//   Free-running raster timing generator for a 256x240 visible frame.
//   It produces pixel/line counters, registered active-high sync pulses and
//   a combinational display-enable flag.
//
// Ports:
//   clk        in   pixel clock, rising-edge active
//   reset      in   asynchronous, active-high reset
//   hsync      out  horizontal sync, active high, registered
//   vsync      out  vertical sync, active high, registered
//   display_on out  high while (hpos,vpos) lies in the visible area
//   hpos       out  horizontal counter, 0..H_MAX
//   vpos       out  vertical counter, 0..V_MAX
module vga_hvsync_generator #(
  parameter int H_DISPLAY = 256,
  parameter int H_BACK    = 23,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_TOP     = 5,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);

  localparam logic [8:0] H_DISP_C     = 9'(H_DISPLAY);
  localparam logic [8:0] H_SYNC_START = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] H_SYNC_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] H_MAX        = 9'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] V_DISP_C     = 9'(V_DISPLAY);
  localparam logic [8:0] V_SYNC_START = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] V_SYNC_END   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic [8:0] V_MAX        = 9'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);

  logic [8:0] hpos_q, hpos_d;
  logic [8:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hmaxxed;

  always_comb begin
    hmaxxed = (hpos_q == H_MAX);
    hpos_d  = hmaxxed ? 9'd0 : hpos_q + 9'd1;
    vpos_d  = vpos_q;
    if (hmaxxed) begin
      vpos_d = (vpos_q == V_MAX) ? 9'd0 : vpos_q + 9'd1;
    end
    // Syncs decode the pre-edge counters, so they trail the counters by one clock.
    hsync_d = (hpos_q >= H_SYNC_START) && (hpos_q <= H_SYNC_END);
    vsync_d = (vpos_q >= V_SYNC_START) && (vpos_q <= V_SYNC_END);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q  <= 9'd0;
      vpos_q  <= 9'd0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  // Unregistered so it lines up with the current hpos/vpos, not the previous one.
  assign display_on = (hpos_q < H_DISP_C) && (vpos_q < V_DISP_C);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// tb_vga_hvsync_generator
//   Scoreboard bench for vga_hvsync_generator. The stimulus process controls
//   reset and queues hand-computed expected outputs keyed by the number of
//   rising edges since reset release; a monitor samples on the falling edge,
//   pops matching entries and compares, and also gathers per-frame statistics.
module tb_vga_hvsync_generator;

  localparam int LINE  = 309;
  localparam int FRAME = 309 * 262;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;

  vga_hvsync_generator dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int    n;
    int    h;
    int    v;
    int    hs;
    int    vs;
    int    de;
    string tag;
  } vec_t;

  vec_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_edges  = 0;

  // Per-run statistics gathered by the monitor over the first frame after release.
  int disp_cnt, vs_cnt, vs_rises, first_vs_n, hs_line0, step_err;
  int prev_h, prev_v, vs_prev;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int n, input int h, input int v, input int hs,
                      input int vs, input int de, input string tag);
    vec_t e;
    e.n = n; e.h = h; e.v = v; e.hs = hs; e.vs = vs; e.de = de; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  // Monitor
  initial begin
    vec_t e;
    int   n, exp_h;
    forever begin
      @(negedge clk);
      if (reset) begin
        disp_cnt = 0; vs_cnt = 0; vs_rises = 0; first_vs_n = -1;
        hs_line0 = 0; step_err = 0; prev_h = 0; prev_v = 0; vs_prev = 0;
      end else begin
        n = n_edges;
        if (n < FRAME) begin
          disp_cnt += int'(display_on);
          vs_cnt   += int'(vsync);
          if (vsync && vs_prev == 0) begin
            vs_rises++;
            if (first_vs_n < 0) first_vs_n = n;
          end
          if (n < LINE) hs_line0 += int'(hsync);
        end
        if (n > 0) begin
          exp_h = (prev_h == LINE - 1) ? 0 : prev_h + 1;
          if (int'(hpos) != exp_h) step_err++;
          if (prev_h != LINE - 1 && int'(vpos) != prev_v) step_err++;
          if (prev_h == LINE - 1 && int'(vpos) != ((prev_v == 261) ? 0 : prev_v + 1)) step_err++;
        end
        prev_h  = int'(hpos);
        prev_v  = int'(vpos);
        vs_prev = int'(vsync);
        while (sb.size() > 0 && sb[0].n <= n) begin
          e = sb.pop_front();
          if (e.n < n) begin
            check({e.tag, ".sampled_at_edge"}, n, e.n);
          end else begin
            check({e.tag, ".hpos"},       int'(hpos),       e.h);
            check({e.tag, ".vpos"},       int'(vpos),       e.v);
            check({e.tag, ".hsync"},      int'(hsync),      e.hs);
            check({e.tag, ".vsync"},      int'(vsync),      e.vs);
            check({e.tag, ".display_on"}, int'(display_on), e.de);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    #1;
    check("rst0.hpos",  int'(hpos),  0);
    check("rst0.vpos",  int'(vpos),  0);
    check("rst0.hsync", int'(hsync), 0);
    check("rst0.vsync", int'(vsync), 0);

    // Run A: from power-up reset to the middle of the vsync pulse.
    //    n      h    v  hs vs de
    push(0,      0,   0, 0, 0, 1, "a_origin");
    push(1,      1,   0, 0, 0, 1, "a_first_edge");
    push(255,    255, 0, 0, 0, 1, "a_last_visible_px");
    push(256,    256, 0, 0, 0, 0, "a_first_border_px");
    push(263,    263, 0, 0, 0, 0, "a_hsync_pre");
    push(264,    264, 0, 1, 0, 0, "a_hsync_rise");
    push(286,    286, 0, 1, 0, 0, "a_hsync_last");
    push(287,    287, 0, 0, 0, 0, "a_hsync_fall");
    push(308,    308, 0, 0, 0, 0, "a_hmax");
    push(309,    0,   1, 0, 0, 1, "a_hwrap");
    push(310,    1,   1, 0, 0, 1, "a_line1");
    push(74106,  255, 239, 0, 0, 1, "a_last_visible");
    push(74160,  0,   240, 0, 0, 0, "a_first_hidden_line");
    push(78486,  0,   254, 0, 0, 0, "a_vsync_pre");
    push(78487,  1,   254, 0, 1, 0, "a_vsync_rise");
    push(78800,  5,   255, 0, 1, 0, "a_in_vsync");

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (78800) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.hpos",  int'(hpos),  0);
    check("rst_mid.vpos",  int'(vpos),  0);
    check("rst_mid.hsync", int'(hsync), 0);
    check("rst_mid.vsync", int'(vsync), 0);
    check("a.hsync_clocks_line0", hs_line0,   23);
    check("a.vsync_rises",        vs_rises,   1);
    check("a.first_vsync_edge",   first_vs_n, 78487);
    check("a.counter_steps_bad",  step_err,   0);
    check("a.queue_left",         sb.size(),  0);
    sb.delete();

    // Run B: one complete frame after a reset taken inside the vsync pulse.
    push(0,      0,   0,   0, 0, 1, "b_origin");
    push(1,      1,   0,   0, 0, 1, "b_first_edge");
    push(78486,  0,   254, 0, 0, 0, "b_vsync_pre");
    push(78487,  1,   254, 0, 1, 0, "b_vsync_rise");
    push(79413,  0,   257, 0, 1, 0, "b_vsync_last");
    push(79414,  1,   257, 0, 0, 0, "b_vsync_fall");
    push(80957,  308, 261, 0, 0, 0, "b_frame_end");
    push(80958,  0,   0,   0, 0, 1, "b_frame_wrap");
    push(80959,  1,   0,   0, 0, 1, "b_frame2");

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (80960) @(posedge clk);
    @(negedge clk);
    #1;
    check("b.display_clocks",     disp_cnt,   61440);
    check("b.vsync_clocks",       vs_cnt,     927);
    check("b.vsync_rises",        vs_rises,   1);
    check("b.first_vsync_edge",   first_vs_n, 78487);
    check("b.hsync_clocks_line0", hs_line0,   23);
    check("b.counter_steps_bad",  step_err,   0);
    check("b.queue_left",         sb.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
